tpram_fifo_ctrl: RTL and testbench
==================================

// Module: tpram_fifo_ctrl
// PURPOSE
//  Sequences one external 128x32 two-port RAM (registered read, 1-cycle latency) as a
//  show-ahead FIFO. Used as the write buffer between the CPU-side cache logic (push) and the
//  SDRAM sequencer (pop). Owns both RAM ports: write pointer, read pointer, occupancy, flags.
//  RAM q is combinational-through to rd_data. No output register.
// PARAMETERS
//  AW     7    RAM address width; depth = 2**AW = 128
//  DW     32   data width
//  AFULL  120  wr_afull asserted when level >= AFULL
// PORTS
//  clock          in   1     system clock; all logic on posedge
//  nreset         in   1     asynchronous active-low reset
//  flush          in   1     synchronous clear of FIFO contents (pointers, level)
//  wr_req         in   1     push request
//  wr_dat         in   DW    push data
//  wr_full        out  1     FIFO holds 2**AW entries; push ignored
//  wr_afull       out  1     level >= AFULL
//  rd_valid       out  1     rd_data holds valid head entry
//  rd_ready       in   1     pop; entry consumed when rd_valid & rd_ready
//  rd_data        out  DW    head entry (= ram_q)
//  level          out  AW+1  committed entries, 0..128
//  err_ovf        out  1     sticky: wr_req while wr_full
//  err_udf        out  1     sticky: rd_ready while !rd_valid
//  ram_wraddress  out  AW    to RAM wraddress
//  ram_wren       out  1     to RAM wren
//  ram_data       out  DW    to RAM data
//  ram_rdaddress  out  AW    to RAM rdaddress
//  ram_q          in   DW    from RAM q
// BEHAVIOUR
//  Reset (nreset low, async): wr_ptr=rd_ptr=0 (AW+1 bits incl. wrap bit), level=0,
//   rd_valid=0, wr_full=0, wr_afull=0, err_ovf=err_udf=0, ram_wren=0.
//  Push: accepted when wr_req & !wr_full. Same cycle: ram_wren=1, ram_wraddress=wr_ptr[AW-1:0],
//   ram_data=wr_dat (combinational); wr_ptr increments at clock edge, wraps 127->0 with
//   wrap bit toggle. wr_req while full: no RAM write, no pointer change, err_ovf set.
//  Pop: accepted when rd_valid & rd_ready; rd_ptr increments at edge.
//  ram_rdaddress = rd_ptr[AW-1:0] + pop (combinational), so ram_q shows the new head the
//   cycle after a pop; back-to-back pops sustain 1 entry/cycle.
//  Visibility: RAM is read-before-write on same address; a pushed entry is poppable no
//   earlier than 2 cycles after its push cycle. Implemented via wr_ptr_d (wr_ptr delayed
//   1 cycle): rd_valid (registered) = (rd_ptr_next != wr_ptr_d_next).
//  Flags: level = wr_ptr - rd_ptr (mod 2**(AW+1)); wr_full = level==2**AW; wr_afull =
//   level>=AFULL; all registered, updated at same edge as pointers.
//  Simultaneous push+pop: both accepted; level unchanged; allowed when full (pop frees slot
//   same cycle? NO - push while full is rejected even if popping same cycle).
//  Empty: rd_valid=0, rd_data don't-care; rd_ready ignored except err_udf.
//  Flush: next edge wr_ptr=rd_ptr=wr_ptr_d=0, level=0, rd_valid=0; push/pop in flush cycle
//   discarded (ram_wren forced 0); error flags NOT cleared (only by reset).
//  Reset mid-operation: contents lost, all state as above; RAM contents undefined, ignored.
// TESTING
//  1 reset, push 0xA0000001 at cycle 0, rd_ready=1 -> rd_valid first high cycle 2,
//    rd_data=0xA0000001, level 1->0 after pop edge.
//  2 push 128 words 0..127 no pops -> wr_full=1 after 128th, wr_afull from 120th, level=128;
//    129th push -> no ram_wren, err_ovf=1, data intact.
//  3 from full, continuous pop 128 cycles -> rd_data 0..127 in order, one per cycle,
//    rd_valid drops after last, level=0.
//  4 steady push+pop every cycle for 300 cycles (wraps pointers twice) -> in-order data,
//    level constant, no error flags.
//  5 10 entries queued, flush with simultaneous wr_req -> level=0, rd_valid=0 next cycle,
//    next push 0x5 pops as 0x5; rd_ready on empty -> err_udf=1.
//  6 nreset pulsed low mid-burst (async, between edges) -> outputs at reset values
//    immediately, FIFO empty after release.

Source files
------------

// File: rtl/tpram_fifo_ctrl.sv
// Show-ahead FIFO controller around an external two-port RAM with registered read.
// Owns both RAM ports plus the pointers, occupancy level and status/error flags.
module tpram_fifo_ctrl #(
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int AFULL = 120
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          flush,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_dat,
    output logic          wr_full,
    output logic          wr_afull,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level,
    output logic          err_ovf,
    output logic          err_udf,
    output logic [AW-1:0] ram_wraddress,
    output logic          ram_wren,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_rdaddress,
    input  logic [DW-1:0] ram_q
);

    localparam logic [AW:0] FULL_LVL  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL);
    localparam logic [AW:0] ZERO_PTR  = '0;

    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0] wr_ptr_d_reg, wr_ptr_d_next;
    logic [AW:0] level_reg, level_next;
    logic        rd_valid_reg, rd_valid_next;
    logic        wr_full_reg, wr_full_next;
    logic        wr_afull_reg, wr_afull_next;
    logic        err_ovf_reg, err_ovf_next;
    logic        err_udf_reg, err_udf_next;
    logic        push;
    logic        pop;

    // A flush cycle discards both sides; reset also keeps the RAM write strobe low.
    assign push = wr_req & ~wr_full_reg & ~flush & nreset;
    assign pop  = rd_valid_reg & rd_ready & ~flush;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg + {{AW{1'b0}}, push};
        rd_ptr_next   = rd_ptr_reg + {{AW{1'b0}}, pop};
        wr_ptr_d_next = wr_ptr_reg;
        if (flush) begin
            wr_ptr_next   = ZERO_PTR;
            rd_ptr_next   = ZERO_PTR;
            wr_ptr_d_next = ZERO_PTR;
        end
    end

    // Level counts every committed write; rd_valid trails by one cycle so the
    // RAM's read-before-write behaviour never exposes a stale word.
    always_comb begin
        level_next    = wr_ptr_next - rd_ptr_next;
        wr_full_next  = (level_next == FULL_LVL);
        wr_afull_next = (level_next >= AFULL_LVL);
        rd_valid_next = (rd_ptr_next != wr_ptr_d_next);
        err_ovf_next  = err_ovf_reg | (wr_req & wr_full_reg);
        err_udf_next  = err_udf_reg | (rd_ready & ~rd_valid_reg);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_d_reg <= '0;
            level_reg    <= '0;
            rd_valid_reg <= 1'b0;
            wr_full_reg  <= 1'b0;
            wr_afull_reg <= 1'b0;
            err_ovf_reg  <= 1'b0;
            err_udf_reg  <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_d_reg <= wr_ptr_d_next;
            level_reg    <= level_next;
            rd_valid_reg <= rd_valid_next;
            wr_full_reg  <= wr_full_next;
            wr_afull_reg <= wr_afull_next;
            err_ovf_reg  <= err_ovf_next;
            err_udf_reg  <= err_udf_next;
        end
    end

    assign ram_wren      = push;
    assign ram_wraddress = wr_ptr_reg[AW-1:0];
    assign ram_data      = wr_dat;
    // Address the next head so ram_q presents it right after a pop.
    assign ram_rdaddress = rd_ptr_next[AW-1:0];
    assign rd_data       = ram_q;

    assign level    = level_reg;
    assign rd_valid = rd_valid_reg;
    assign wr_full  = wr_full_reg;
    assign wr_afull = wr_afull_reg;
    assign err_ovf  = err_ovf_reg;
    assign err_udf  = err_udf_reg;

endmodule

// File: tb/tb_tpram_fifo_ctrl.sv
// Bench for tpram_fifo_ctrl with a behavioural 128x32 registered-read RAM and a
// scoreboard queue checked by an independent pop monitor.
module tb_tpram_fifo_ctrl;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        flush = 1'b0;
    logic        wr_req = 1'b0;
    logic [31:0] wr_dat = '0;
    logic        wr_full, wr_afull, rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic [7:0]  level;
    logic        err_ovf, err_udf;
    logic [6:0]  ram_wraddress, ram_rdaddress;
    logic        ram_wren;
    logic [31:0] ram_data, ram_q;

    logic [31:0] mem [128];
    logic [31:0] sb_q [$];
    int checks = 0;
    int failures = 0;

    tpram_fifo_ctrl dut (
        .clock(clock), .nreset(nreset), .flush(flush),
        .wr_req(wr_req), .wr_dat(wr_dat), .wr_full(wr_full), .wr_afull(wr_afull),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .level(level),
        .err_ovf(err_ovf), .err_udf(err_udf),
        .ram_wraddress(ram_wraddress), .ram_wren(ram_wren), .ram_data(ram_data),
        .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // Read-before-write RAM with one cycle of read latency.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_wraddress] <= ram_data;
        ram_q <= mem[ram_rdaddress];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected word.
    always @(negedge clock) begin
        if (nreset && rd_valid && rd_ready && !flush) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got %0h expected no entry", rd_data);
            end else begin
                check("rd_data", rd_data, sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_level", 32'(level), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_full", 32'(wr_full), 32'd0);
        check("rst_wr_afull", 32'(wr_afull), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        check("rst_err_udf", 32'(err_udf), 32'd0);
        check("rst_ram_wren", 32'(ram_wren), 32'd0);
    endtask

    task automatic do_reset();
        wr_req = 1'b0; rd_ready = 1'b0; flush = 1'b0; wr_dat = '0;
        #2 nreset = 1'b0;
        #1 check_reset_state();
        repeat (2) @(posedge clock);
        #3 nreset = 1'b1;
        sb_q.delete();
        tick();
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_req = 1'b1; wr_dat = d;
        sb_q.push_back(d);
        tick();
        wr_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        wr_req = 1'b0;
        for (int k = 0; k < budget && (sb_q.size() != 0 || rd_valid); k++) begin
            rd_ready = rd_valid;
            tick();
        end
        rd_ready = 1'b0;
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single push, first visible two cycles later
        do_reset();
        wr_req = 1'b1; wr_dat = 32'hA000_0001; rd_ready = 1'b1;
        sb_q.push_back(wr_dat);
        @(negedge clock);
        check("t1_c0_wren", 32'(ram_wren), 32'd1);
        check("t1_c0_waddr", 32'(ram_wraddress), 32'd0);
        check("t1_c0_valid", 32'(rd_valid), 32'd0);
        tick();
        wr_req = 1'b0;
        @(negedge clock);
        check("t1_c1_valid", 32'(rd_valid), 32'd0);
        check("t1_c1_level", 32'(level), 32'd1);
        tick();
        @(negedge clock);
        check("t1_c2_valid", 32'(rd_valid), 32'd1);
        check("t1_c2_level", 32'(level), 32'd1);
        tick();
        rd_ready = 1'b0;
        @(negedge clock);
        check("t1_c3_valid", 32'(rd_valid), 32'd0);
        check("t1_c3_level", 32'(level), 32'd0);
        check("t1_err_udf", 32'(err_udf), 32'd1);
        check("t1_queue", 32'(sb_q.size()), 32'd0);

        // 2: fill to 128, then one rejected push
        do_reset();
        for (int i = 0; i < 128; i++) begin
            wr_req = 1'b1; wr_dat = 32'(i);
            sb_q.push_back(wr_dat);
            @(negedge clock);
            check("t2_level", 32'(level), 32'(i));
            check("t2_afull", 32'(wr_afull), 32'(i >= 120));
            check("t2_full", 32'(wr_full), 32'd0);
            check("t2_waddr", 32'(ram_wraddress), 32'(i));
            tick();
        end
        wr_req = 1'b0;
        @(negedge clock);
        check("t2_level_full", 32'(level), 32'd128);
        check("t2_full_set", 32'(wr_full), 32'd1);
        check("t2_afull_set", 32'(wr_afull), 32'd1);
        tick();
        wr_req = 1'b1; wr_dat = 32'hDEAD_BEEF;
        @(negedge clock);
        check("t2_ovf_wren", 32'(ram_wren), 32'd0);
        tick();
        wr_req = 1'b0;
        @(negedge clock);
        check("t2_err_ovf", 32'(err_ovf), 32'd1);
        check("t2_level_hold", 32'(level), 32'd128);

        // 3: drain from full, one word per cycle
        tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clock);
            check("t3_valid", 32'(rd_valid), 32'd1);
            tick();
        end
        rd_ready = 1'b0;
        @(negedge clock);
        check("t3_valid_drop", 32'(rd_valid), 32'd0);
        check("t3_level", 32'(level), 32'd0);
        check("t3_err_udf", 32'(err_udf), 32'd0);
        check("t3_queue", 32'(sb_q.size()), 32'd0);

        // 4: 300 cycles of push with pop whenever valid
        do_reset();
        for (int i = 0; i < 300; i++) begin
            wr_req = 1'b1; wr_dat = 32'h4000_0000 + 32'(i);
            rd_ready = rd_valid;
            sb_q.push_back(wr_dat);
            @(negedge clock);
            if (i >= 2) begin
                check("t4_level", 32'(level), 32'd2);
                check("t4_valid", 32'(rd_valid), 32'd1);
            end
            tick();
        end
        drain(10);
        @(negedge clock);
        check("t4_level_end", 32'(level), 32'd0);
        check("t4_err_ovf", 32'(err_ovf), 32'd0);
        check("t4_err_udf", 32'(err_udf), 32'd0);

        // 5: flush with a simultaneous push, then reuse and underflow
        do_reset();
        for (int i = 0; i < 10; i++) push_word(32'h100 + 32'(i));
        tick(); tick();
        @(negedge clock);
        check("t5_level10", 32'(level), 32'd10);
        tick();
        flush = 1'b1; wr_req = 1'b1; wr_dat = 32'h0000_0BAD;
        @(negedge clock);
        check("t5_flush_wren", 32'(ram_wren), 32'd0);
        sb_q.delete();
        tick();
        flush = 1'b0; wr_req = 1'b0;
        @(negedge clock);
        check("t5_flush_level", 32'(level), 32'd0);
        check("t5_flush_valid", 32'(rd_valid), 32'd0);
        check("t5_flush_ovf", 32'(err_ovf), 32'd0);
        tick();
        push_word(32'h5);
        drain(10);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        @(negedge clock);
        check("t5_err_udf", 32'(err_udf), 32'd1);

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_req = 1'b1; wr_dat = 32'h600 + 32'(i);
            rd_ready = rd_valid;
            sb_q.push_back(wr_dat);
            tick();
        end
        #2 nreset = 1'b0;
        #1 check_reset_state();
        sb_q.delete();
        wr_req = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        #3 nreset = 1'b1;
        tick();
        @(negedge clock);
        check("t6_level", 32'(level), 32'd0);
        check("t6_valid", 32'(rd_valid), 32'd0);
        tick();
        push_word(32'h77);
        drain(10);
        @(negedge clock);
        check("t6_level_end", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
